// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: widths, entry program counter, FSM encoding and queue entry layout.
// Pure declarations; no latency or backpressure of its own.
package instr_fetch_unit_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 5'd4;
  localparam int DEF_QDEPTH = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // The PC wraps from the last word back to 0.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side buses: instruction memory port plus the {pc, instr} valid/ready link to decode.
// master = fetch unit; slave = memory and decode; no state, decode backpressures via id_ready.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic              imem_wr;
  logic [DATA_W-1:0] imem_d_in;
  logic [DATA_W-1:0] imem_d_out;

  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  modport master (
    output imem_addr, imem_rd, imem_wr, imem_d_in,
    input  imem_d_out,
    output if_valid, if_instr, if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_addr, imem_rd, imem_wr, imem_d_in,
    output imem_d_out,
    input  if_valid, if_instr, if_pc,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous FIFO with flush and a registered head entry; a push is visible at the head one edge later.
// Push+pop together is legal at any fill level; the caller never pushes into a full queue without popping.
module instr_fetch_unit_fetch_queue #(
  parameter  int W     = 37,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_vld,
  output logic [W-1:0]     head_dat
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic             do_pop;
  logic             do_push;

  assign do_pop    = pop & (count != '0);
  assign do_push   = push & ~flush;
  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign head_vld  = (count != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= push_dat;
  end

  // Head tracks the entry that will sit at rd_ptr after this edge, bypassing storage when the queue drains to the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_dat <= '0;
    end else if (!flush) begin
      if (do_push && (count == '0 || (count == CNT_ONE && do_pop)))
        head_dat <= push_dat;
      else if (do_pop && count > CNT_ONE)
        head_dat <= mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives imem from the PC, queues {pc, instr}; fetched word reaches decode one edge after its address.
// Fetching stops when the queue is full with no pop, on fetch_en=0, on redirect and in HALT; redirect flushes.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                QDEPTH       = DEF_QDEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC     = DEF_RESET_PC,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_en,
  input  logic                redirect_en,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted,
  output logic [15:0]         fetch_count,
  instr_fetch_unit_if.master  fbus
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W-1:0] QFULL = CNT_W'(QDEPTH);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       cnt_q;
  logic [CNT_W-1:0]  q_count;
  logic              head_vld;
  logic              pop;
  logic              fetch;
  fetch_entry_t      push_ent;
  fetch_entry_t      head_ent;

  assign pop   = head_vld & fbus.id_ready;
  assign fetch = ~reset & (state_q == ST_RUN) & fetch_en & ~redirect_en
               & ((q_count < QFULL) | ((q_count == QFULL) & pop));

  assign push_ent.pc    = pc_q;
  assign push_ent.instr = fbus.imem_d_out;

  always_comb begin
    state_d = state_q;
    if (redirect_en)
      state_d = ST_RUN;
    else if (fetch && HALT_ON_ZERO && fbus.imem_d_out == '0)
      state_d = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset)            pc_q <= RESET_PC;
    else if (redirect_en) pc_q <= redirect_pc;
    else if (fetch)       pc_q <= pc_incr(pc_q);
  end

  always_ff @(posedge clk) begin
    if (reset)                          cnt_q <= '0;
    else if (fetch && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  // A redirect discards any concurrent pop along with the queue contents.
  instr_fetch_unit_fetch_queue #(
    .W     (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (fetch),
    .push_dat (push_ent),
    .pop      (pop & ~redirect_en),
    .flush    (redirect_en),
    .count    (q_count),
    .head_vld (head_vld),
    .head_dat (head_ent)
  );

  assign fbus.imem_addr = pc_q;
  assign fbus.imem_rd   = fetch;
  assign fbus.imem_wr   = 1'b0;
  assign fbus.imem_d_in = '0;
  assign fbus.if_valid  = head_vld;
  assign fbus.if_instr  = head_ent.instr;
  assign fbus.if_pc     = head_ent.pc;

  assign halted      = (state_q == ST_HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed plan steps then random traffic against a queue-based reference.
module tb_instr_fetch_unit;

  localparam int QD = 2;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect_en;
  logic [4:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [31:0] mem [32];

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_pc   = 5'd4;
  bit          m_halt = 0;
  logic [15:0] m_cnt  = 16'd0;

  instr_fetch_unit_if bif ();

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_count (fetch_count),
    .fbus        (bif)
  );

  assign bif.imem_d_out = mem[bif.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare against the reference just before the edge, then advance the reference by one cycle.
  task automatic tick();
    int sz;
    bit pop;
    bit rd;
    #1;
    sz  = mq.size();
    pop = (sz > 0) && bif.id_ready;
    rd  = !reset && !m_halt && fetch_en && !redirect_en && (sz < QD || (sz == QD && pop));
    if (armed) begin
      check("imem_rd", {31'd0, bif.imem_rd}, {31'd0, rd});
      check("imem_addr", {27'd0, bif.imem_addr}, {27'd0, m_pc});
      check("if_valid", {31'd0, bif.if_valid}, {31'd0, sz > 0});
      if (sz > 0) begin
        check("if_pc", {27'd0, bif.if_pc}, {27'd0, mq[0].pc});
        check("if_instr", bif.if_instr, mq[0].instr);
      end
      check("halted", {31'd0, halted}, {31'd0, m_halt});
      check("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
      check("imem_wr_tie", {bif.imem_wr, bif.imem_d_in[30:0]}, 32'd0);
    end
    if (reset) begin
      mq.delete();
      m_pc   = 5'd4;
      m_halt = 0;
      m_cnt  = 16'd0;
    end else if (redirect_en) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_halt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rd) begin
        mq.push_back('{m_pc, mem[m_pc]});
        if (mem[m_pc] == 32'd0) m_halt = 1;
        m_pc = m_pc + 5'd1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect_en = 1'b0; redirect_pc = 5'd0;
    bif.id_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom | 32'h1;
    mem[8] = 32'd0;
    @(negedge clk);
    tick();
    armed = 1;
    tick();
    check("rst_if_valid", {31'd0, bif.if_valid}, 32'd0);
    check("rst_if_instr", bif.if_instr, 32'd0);
    check("rst_if_pc", {27'd0, bif.if_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", {16'd0, fetch_count}, 32'd0);
    check("rst_addr", {27'd0, bif.imem_addr}, 32'd4);

    // Plan 1: straight-line run to the zero word at address 8.
    reset = 1'b0; fetch_en = 1'b1; bif.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_if_pc", {27'd0, bif.if_pc}, 32'(4 + k));
      check("t1_if_instr", bif.if_instr, mem[4 + k]);
    end
    check("t1_halted", {31'd0, halted}, 32'd1);
    tick();
    tick();
    check("t1_count", {16'd0, fetch_count}, 32'd5);
    check("t1_rd_off", {31'd0, bif.imem_rd}, 32'd0);

    // Plan 2: decode stalled from reset fills the queue with pc 4,5.
    do_reset();
    bif.id_ready = 1'b0;
    tick(); tick(); tick();
    #1;
    check("t2_addr_held", {27'd0, bif.imem_addr}, 32'd6);
    check("t2_rd_off", {31'd0, bif.imem_rd}, 32'd0);
    check("t2_head", {27'd0, bif.if_pc}, 32'd4);
    check("t2_count", {16'd0, fetch_count}, 32'd2);
    bif.id_ready = 1'b1;
    tick();
    check("t2_if_pc5", {27'd0, bif.if_pc}, 32'd5);
    tick();
    check("t2_if_pc6", {27'd0, bif.if_pc}, 32'd6);

    // Plan 3: redirect to 30 with a full queue, then wrap through 31 -> 0.
    redirect_en = 1'b1; redirect_pc = 5'd30;
    tick();
    redirect_en = 1'b0;
    check("t3_flushed", {31'd0, bif.if_valid}, 32'd0);
    tick();
    check("t3_pc30", {27'd0, bif.if_pc}, 32'd30);
    check("t3_instr30", bif.if_instr, mem[30]);
    tick();
    check("t3_pc31", {27'd0, bif.if_pc}, 32'd31);
    tick();
    check("t3_pc0", {27'd0, bif.if_pc}, 32'd0);
    check("t3_instr0", bif.if_instr, mem[0]);
    for (int i = 0; i < 40 && !m_halt; i++) tick();
    check("t3_halt_reached", {31'd0, halted}, 32'd1);
    tick(); tick();

    // Plan 4: redirect out of HALT.
    redirect_en = 1'b1; redirect_pc = 5'd4;
    tick();
    redirect_en = 1'b0;
    check("t4_unhalt", {31'd0, halted}, 32'd0);
    tick();
    check("t4_resume_pc", {27'd0, bif.if_pc}, 32'd4);
    check("t4_count", {16'd0, fetch_count}, {16'd0, m_cnt});

    // Plan 5: fetch_en pattern 1,0,0,1.
    do_reset();
    bif.id_ready = 1'b1;
    fetch_en = 1'b1; tick();
    check("t5_v0", {31'd0, bif.if_valid}, 32'd1);
    fetch_en = 1'b0; tick();
    check("t5_v1", {31'd0, bif.if_valid}, 32'd0);
    tick();
    check("t5_v2", {31'd0, bif.if_valid}, 32'd0);
    fetch_en = 1'b1; tick();
    check("t5_v3", {31'd0, bif.if_valid}, 32'd1);
    check("t5_pc5", {27'd0, bif.if_pc}, 32'd5);
    check("t5_addr", {27'd0, bif.imem_addr}, 32'd6);
    check("t5_count", {16'd0, fetch_count}, 32'd2);

    // Plan 6: reset with a full queue and a fetch in flight.
    do_reset();
    bif.id_ready = 1'b0; fetch_en = 1'b1;
    tick(); tick();
    bif.id_ready = 1'b1;
    reset = 1'b1;
    tick();
    check("t6_if_valid", {31'd0, bif.if_valid}, 32'd0);
    check("t6_if_instr", bif.if_instr, 32'd0);
    check("t6_if_pc", {27'd0, bif.if_pc}, 32'd0);
    check("t6_halted", {31'd0, halted}, 32'd0);
    check("t6_count", {16'd0, fetch_count}, 32'd0);
    check("t6_addr", {27'd0, bif.imem_addr}, 32'd4);
    reset = 1'b0;

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      fetch_en     = ($urandom_range(0, 3) != 0);
      bif.id_ready = ($urandom_range(0, 4) < 3);
      redirect_en  = ($urandom_range(0, 19) == 0);
      redirect_pc  = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0; redirect_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
